pio_tx_inject: RTL

PIO_TX_INJECT -- requirements
Module: pio_tx_inject

---
 rtl/pio_tunnel_pkg.sv | 12 +
 rtl/pio_tx_inject.sv | 81 ++++++++
 2 files changed

// File: rtl/pio_tunnel_pkg.sv
// pio_tunnel_pkg: tunnel FIFO word layout and TX state encoding shared by the TX inject and RX snoop sides.
package pio_tunnel_pkg;
  localparam int DATA_MSB = 63;
  localparam int START = 64;
  localparam int LAST = 65;
  localparam int EN_LO = 66;
  localparam int EN_HI = 67;
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, ABORT = 2'd2} tx_state_t;
  function automatic logic [7:0] keep_map(input logic en_lo, input logic en_hi);
    return {{4{en_hi}}, {4{en_lo}}};
  endfunction
endpackage

// File: rtl/pio_tx_inject.sv
// pio_tx_inject: drains the tunnel FIFO onto the PCIe AXIS TX port, dropping orphans,
// closing truncated TLPs with a discontinue beat and spacing TLPs by GAP idle cycles.
module pio_tx_inject
  import pio_tunnel_pkg::*;
#(
  parameter logic [2:0] GAP = 3'd7
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic [71:0] dout,
  input  logic        empty,
  output logic        rd_en,
  output logic [63:0] s_axis_tx_tdata,
  output logic [7:0]  s_axis_tx_tkeep,
  output logic        s_axis_tx_tlast,
  output logic        s_axis_tx_tvalid,
  input  logic        s_axis_tx_tready,
  output logic [3:0]  s_axis_tx_tuser,
  input  logic [5:0]  tx_buf_av,
  output logic [31:0] pkt_cnt,
  output logic [15:0] drop_cnt
);
  tx_state_t state, state_nxt;
  logic [2:0] gap, gap_nxt;
  logic accept, avail, head_start, head_last, start_ok, pop, load, load_abort;
  logic unused_bits;
  assign unused_bits = ^dout[71:68];
  assign rd_en = pop;
  always_comb begin
    accept = s_axis_tx_tvalid & s_axis_tx_tready;
    avail = !empty & (!s_axis_tx_tvalid | accept) & !sys_rst;
    head_start = dout[START];
    head_last = dout[LAST];
    gap_nxt = (accept & s_axis_tx_tlast) ? GAP : (gap != 3'd0 ? gap - 3'd1 : 3'd0);
    // looking at the next gap value lets the start beat land exactly GAP idle cycles after tlast
    start_ok = (gap_nxt == 3'd0) && (tx_buf_av != 6'd0);
    state_nxt = state;
    pop = 1'b0;
    load = 1'b0;
    load_abort = 1'b0;
    case (state)
      IDLE: if (avail & (!head_start | start_ok)) begin
        pop = 1'b1;
        load = head_start;
        state_nxt = (head_start & !head_last) ? DATA : IDLE;
      end
      DATA: if (avail) begin
        pop = !head_start;
        load = !head_start;
        load_abort = head_start;
        state_nxt = head_start ? ABORT : (head_last ? IDLE : DATA);
      end
      default: state_nxt = (state == ABORT && !accept) ? ABORT : IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      gap <= 3'd0;
      s_axis_tx_tvalid <= 1'b0;
      s_axis_tx_tdata <= '0;
      s_axis_tx_tkeep <= '0;
      s_axis_tx_tlast <= 1'b0;
      s_axis_tx_tuser <= '0;
      pkt_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      gap <= gap_nxt;
      if (load | load_abort) begin
        s_axis_tx_tvalid <= 1'b1;
        s_axis_tx_tdata <= load_abort ? 64'd0 : dout[DATA_MSB:0];
        s_axis_tx_tkeep <= load_abort ? 8'h0F : keep_map(dout[EN_LO], dout[EN_HI]);
        s_axis_tx_tlast <= load_abort | dout[LAST];
        s_axis_tx_tuser <= load_abort ? 4'h8 : 4'h0;
      end else if (accept) s_axis_tx_tvalid <= 1'b0;
      if (accept & s_axis_tx_tlast & !s_axis_tx_tuser[3]) pkt_cnt <= pkt_cnt + 32'd1;
      if (pop & !load & (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
endmodule
